// File: rtl/fpu_lat_pipe.sv
// Elastic result pipeline for FPU operation groups: NUM_STAGES valid/ready register slices.
// Empty stages always accept, so bubbles collapse. NUM_STAGES=0 gives a wire-through.
module fpu_lat_pipe #(
    parameter int WIDTH      = 32,
    parameter int NUM_FLAGS  = 5,
    parameter int TAG_W      = 5,
    parameter int NUM_STAGES = 1,
    parameter int OCC_W      = (NUM_STAGES > 0) ? $clog2(NUM_STAGES + 1) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_result_i,
    input  logic [NUM_FLAGS-1:0] in_flags_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_result_o,
    output logic [NUM_FLAGS-1:0] out_flags_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic                 busy_o,
    output logic [OCC_W-1:0]     occupancy_o
);

    generate
        if (NUM_STAGES == 0) begin : g_pass
            // Clock, reset and flush have nothing to act on without storage.
            logic unused_ok;
            assign unused_ok    = ^{clk_i, rst_ni, flush_i};

            assign in_ready_o   = out_ready_i;
            assign out_valid_o  = in_valid_i;
            assign out_result_o = in_result_i;
            assign out_flags_o  = in_flags_i;
            assign out_tag_o    = in_tag_i;
            assign busy_o       = in_valid_i;
            assign occupancy_o  = '0;
        end else begin : g_pipe
            typedef struct packed {
                logic [WIDTH-1:0]     result;
                logic [NUM_FLAGS-1:0] flags;
                logic [TAG_W-1:0]     tag;
            } payload_t;

            payload_t              in_payload;
            logic [NUM_STAGES-1:0] valid_q, valid_d;
            payload_t              data_q  [NUM_STAGES];
            payload_t              data_d  [NUM_STAGES];
            logic [NUM_STAGES-1:0] up_valid;
            payload_t              up_data [NUM_STAGES];
            logic [NUM_STAGES:0]   ready;
            logic [OCC_W-1:0]      occ_q, occ_d;

            assign in_payload = {in_result_i, in_flags_i, in_tag_i};

            // A stage can take new data if it is empty or its occupant moves on this cycle.
            always_comb begin
                logic [NUM_STAGES:0] rdy;
                rdy[NUM_STAGES] = out_ready_i;
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    rdy[k] = !valid_q[k] || rdy[k + 1];
                end
                ready = rdy;
            end

            always_comb begin
                up_valid[0] = in_valid_i;
                up_data[0]  = in_payload;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    up_valid[k] = valid_q[k - 1];
                    up_data[k]  = data_q[k - 1];
                end
            end

            always_comb begin
                // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
                valid_d = valid_q;
                data_d  = data_q;
                occ_d   = '0;
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (ready[k]) begin
                        valid_d[k] = up_valid[k];
                        if (up_valid[k]) begin
                            data_d[k] = up_data[k];
                        end
                    end
                end
                // Flush wins over every transfer; payload left as-is is harmless once invalid.
                if (flush_i) begin
                    valid_d = '0;
                end
                for (int k = 0; k < NUM_STAGES; k++) begin
                    occ_d = occ_d + OCC_W'(valid_d[k]);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= '0;
                    occ_q   <= '0;
                    // NOTE: payload is reset too so out_* read zero after reset, not stale data.
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
                    valid_q <= valid_d;
                    occ_q   <= occ_d;
                    data_q  <= data_d;
                end
            end

            assign in_ready_o   = ready[0];
            assign out_valid_o  = valid_q[NUM_STAGES-1];
            assign out_result_o = data_q[NUM_STAGES-1].result;
            assign out_flags_o  = data_q[NUM_STAGES-1].flags;
            assign out_tag_o    = data_q[NUM_STAGES-1].tag;
            assign busy_o       = (|valid_q) || in_valid_i;
            assign occupancy_o  = occ_q;
        end
    endgenerate

endmodule

// File: tb/tb_fpu_lat_pipe.sv
// Self-checking bench for fpu_lat_pipe: four instances (3, 2, 4 and 0 stages), directed
// scenarios plus random traffic compared against a slot-position queue model.
module tb_fpu_lat_pipe;

    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [ND-1:0] in_valid, flush, out_ready, in_ready, out_valid, busy;
    logic [31:0]   in_res;
    logic [4:0]    in_fl, in_tag;
    logic [31:0]   o_res [ND];
    logic [4:0]    o_fl  [ND];
    logic [4:0]    o_tag [ND];
    logic [1:0]    occ0, occ1;
    logic [2:0]    occ2;
    logic [0:0]    occ3;

    always #5 clk = ~clk;

    fpu_lat_pipe #(.NUM_STAGES(3)) u_n3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
        .in_ready_o(in_ready[0]), .in_result_i(in_res), .in_flags_i(in_fl), .in_tag_i(in_tag),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_result_o(o_res[0]),
        .out_flags_o(o_fl[0]), .out_tag_o(o_tag[0]), .busy_o(busy[0]), .occupancy_o(occ0)
    );
    fpu_lat_pipe #(.NUM_STAGES(2)) u_n2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
        .in_ready_o(in_ready[1]), .in_result_i(in_res), .in_flags_i(in_fl), .in_tag_i(in_tag),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_result_o(o_res[1]),
        .out_flags_o(o_fl[1]), .out_tag_o(o_tag[1]), .busy_o(busy[1]), .occupancy_o(occ1)
    );
    fpu_lat_pipe #(.NUM_STAGES(4)) u_n4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
        .in_ready_o(in_ready[2]), .in_result_i(in_res), .in_flags_i(in_fl), .in_tag_i(in_tag),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_result_o(o_res[2]),
        .out_flags_o(o_fl[2]), .out_tag_o(o_tag[2]), .busy_o(busy[2]), .occupancy_o(occ2)
    );
    fpu_lat_pipe #(.NUM_STAGES(0)) u_n0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[3]), .in_valid_i(in_valid[3]),
        .in_ready_o(in_ready[3]), .in_result_i(in_res), .in_flags_i(in_fl), .in_tag_i(in_tag),
        .out_valid_o(out_valid[3]), .out_ready_i(out_ready[3]), .out_result_o(o_res[3]),
        .out_flags_o(o_fl[3]), .out_tag_o(o_tag[3]), .busy_o(busy[3]), .occupancy_o(occ3)
    );

    // Reference model: in-flight items, oldest first, each with the slot it occupies.
    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [4:0]  tag;
        int          pos;
    } item_t;

    item_t mq[$];
    item_t nq[$];
    int    cur = 0;
    int    mn  = 3;
    int    checks = 0;
    int    errors = 0;

    bit          obs_ov, obs_ir;
    int          obs_occ;
    logic [4:0]  obs_tag;
    logic [31:0] obs_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    function automatic int stages_of(input int d);
        case (d)
            0: return 3;
            1: return 2;
            2: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic sample_outputs();
        obs_ov  = out_valid[cur];
        obs_ir  = in_ready[cur];
        obs_tag = o_tag[cur];
        obs_res = o_res[cur];
        case (cur)
            0: obs_occ = int'(occ0);
            1: obs_occ = int'(occ1);
            2: obs_occ = int'(occ2);
            default: obs_occ = int'(occ3);
        endcase
    endtask

    // One clock cycle: drive at negedge, compare just after, advance the model at posedge.
    task automatic cyc(input bit v, input bit f, input bit ordy,
                       input logic [31:0] res, input logic [4:0] fl, input logic [4:0] tag);
        int    ahead;
        bit    exp_ov;
        item_t it;
        @(negedge clk);
        in_valid       = '0;
        flush          = '0;
        out_ready      = '1;
        in_valid[cur]  = v;
        flush[cur]     = f;
        out_ready[cur] = ordy;
        in_res         = res;
        in_fl          = fl;
        in_tag         = tag;
        #1;
        sample_outputs();
        if (mn == 0) begin
            check("pass_valid", 32'(obs_ov), 32'(v));
            check("pass_result", obs_res, res);
            check("pass_flags", 32'(o_fl[cur]), 32'(fl));
            check("pass_tag", 32'(obs_tag), 32'(tag));
            check("pass_ready", 32'(obs_ir), 32'(ordy));
            check("pass_occ", obs_occ, 0);
            check("pass_busy", 32'(busy[cur]), 32'(v));
        end else begin
            exp_ov = (mq.size() > 0) && (mq[0].pos == mn - 1);
            check("out_valid", 32'(obs_ov), 32'(exp_ov));
            if (exp_ov) begin
                check("out_result", obs_res, mq[0].res);
                check("out_flags", 32'(o_fl[cur]), 32'(mq[0].fl));
                check("out_tag", 32'(obs_tag), 32'(mq[0].tag));
            end
            check("occupancy", obs_occ, mq.size());
            check("busy", 32'(busy[cur]), 32'((mq.size() > 0) || v));
            // Items advance one slot unless the slot ahead stays taken; the oldest may leave.
            nq    = {};
            ahead = mn;
            foreach (mq[i]) begin
                it = mq[i];
                if (i == 0 && it.pos == mn - 1 && ordy) continue;
                if (it.pos + 1 < ahead) it.pos = it.pos + 1;
                ahead = it.pos;
                nq.push_back(it);
            end
            check("in_ready", 32'(obs_ir), 32'(ahead > 0));
            if (f) begin
                nq = {};
            end else if (v && ahead > 0) begin
                it.res = res; it.fl = fl; it.tag = tag; it.pos = 0;
                nq.push_back(it);
            end
        end
        @(posedge clk);
        if (mn > 0) mq = nq;
    endtask

    task automatic rcyc(input bit v, input bit f, input bit ordy);
        cyc(v, f, ordy, $urandom, 5'($urandom), 5'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() > 0 && n < 20) begin
            rcyc(1'b0, 1'b0, 1'b1);
            n++;
        end
        check("drain_empty", mq.size(), 0);
    endtask

    task automatic set_dut(input int d);
        drain();
        cur = d;
        mn  = stages_of(d);
        mq  = {};
    endtask

    // Push one item into an empty pipe and count cycles until it is visible at the output.
    task automatic latency_probe(input logic [31:0] res, input logic [4:0] fl, input logic [4:0] tag);
        int lat = -1;
        cyc(1'b1, 1'b0, 1'b1, res, fl, tag);
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            rcyc(1'b0, 1'b0, 1'b1);
            if (obs_ov) begin
                lat = k;
                check("lat_tag", 32'(obs_tag), 32'(tag));
                check("lat_result", obs_res, res);
            end
        end
        check("latency", lat, mn);
    endtask

    initial begin
        logic [4:0] got[$];
        int         cnt;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] got[$];
        int         cnt;

        in_valid  = '0;
        flush     = '0;
        out_ready = '1;
        in_res    = '0;
        in_fl     = '0;
        in_tag    = '0;

        // Reset state
        #12;
        sample_outputs();
        check("rst_out_valid", 32'(obs_ov), 0);
        check("rst_out_result", obs_res, 0);
        check("rst_out_tag", 32'(obs_tag), 0);
        check("rst_occ", obs_occ, 0);
        check("rst_in_ready", 32'(obs_ir), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 stages: latency and fill-up occupancy
        set_dut(0);
        latency_probe(32'h3F80_0000, 5'h01, 5'd5);
        drain();
        rcyc(1'b1, 1'b0, 1'b1);
        rcyc(1'b1, 1'b0, 1'b1);
        check("occ_fill_1", obs_occ, 1);
        rcyc(1'b1, 1'b0, 1'b1);
        check("occ_fill_2", obs_occ, 2);
        rcyc(1'b0, 1'b0, 1'b1);
        check("occ_fill_3", obs_occ, 3);

        // 2 stages: stall, backpressure, in-order release
        set_dut(1);
        cyc(1'b1, 1'b0, 1'b0, 32'h100, 5'h0, 5'd0);
        check("bp_accept0", 32'(obs_ir), 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h101, 5'h0, 5'd1);
        check("bp_accept1", 32'(obs_ir), 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h102, 5'h0, 5'd2);
        check("bp_block2", 32'(obs_ir), 0);
        cyc(1'b1, 1'b0, 1'b0, 32'h102, 5'h0, 5'd2);
        check("bp_block2b", 32'(obs_ir), 0);
        check("bp_occ_full", obs_occ, 2);
        got = {};
        cyc(1'b1, 1'b0, 1'b1, 32'h102, 5'h0, 5'd2);
        check("bp_pushpop", 32'(obs_ir), 1);
        if (obs_ov) got.push_back(obs_tag);
        cyc(1'b1, 1'b0, 1'b1, 32'h103, 5'h0, 5'd3);
        if (obs_ov) got.push_back(obs_tag);
        for (int k = 0; k < 8 && got.size() < 4; k++) begin
            rcyc(1'b0, 1'b0, 1'b1);
            if (obs_ov) got.push_back(obs_tag);
        end
        check("bp_exit_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) check("bp_exit_order", 32'(got[i]), i);

        // 4 stages: bubble collapse behind a stalled head
        set_dut(2);
        cyc(1'b1, 1'b0, 1'b0, 32'hAAAA_0007, 5'h02, 5'd7);
        for (int k = 0; k < 3; k++) rcyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'hBBBB_0009, 5'h04, 5'd9);
        check("col_head_valid", 32'(obs_ov), 1);
        check("col_head_tag", 32'(obs_tag), 7);
        rcyc(1'b0, 1'b0, 1'b0);
        rcyc(1'b0, 1'b0, 1'b0);
        rcyc(1'b0, 1'b0, 1'b0);
        check("col_occ", obs_occ, 2);
        rcyc(1'b0, 1'b0, 1'b1);
        check("col_pop_tag", 32'(obs_tag), 7);
        rcyc(1'b0, 1'b0, 1'b1);
        check("col_next_valid", 32'(obs_ov), 1);
        check("col_next_tag", 32'(obs_tag), 9);

        // 3 stages: flush with a simultaneous input
        set_dut(0);
        for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 1'b0, 32'(k), 5'h0, 5'(k));
        cyc(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'h1F, 5'd30);
        rcyc(1'b0, 1'b0, 1'b1);
        check("flush_valid", 32'(obs_ov), 0);
        check("flush_occ", obs_occ, 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            rcyc(1'b0, 1'b0, 1'b1);
            if (obs_ov) cnt++;
        end
        check("flush_no_emerge", cnt, 0);

        // 3 stages: asynchronous reset mid-cycle with items in flight
        rcyc(1'b1, 1'b0, 1'b0);
        rcyc(1'b1, 1'b0, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = '0;
        #1;
        sample_outputs();
        check("arst_valid", 32'(obs_ov), 0);
        check("arst_occ", obs_occ, 0);
        check("arst_in_ready", 32'(obs_ir), 1);
        mq = {};
        @(negedge clk);
        rst_n = 1'b1;
        latency_probe(32'h4000_0000, 5'h08, 5'd12);

        // Random traffic on every registered variant
        for (int d = 0; d < 3; d++) begin
            set_dut(d);
            for (int k = 0; k < 300; k++) begin
                rcyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 9) < 6));
            end
        end

        // Zero-stage passthrough
        set_dut(3);
        for (int k = 0; k < 30; k++) begin
            rcyc(1'(($urandom)), 1'(($urandom)), 1'(($urandom)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_lat_pipe.md
Name: fpu_lat_pipe

Overview:
- Parametrised, elastic result pipeline for the FPU operation groups (FP32/FP16/FP8/divsqrt post-processing).
- Replaces the fixed per-format latency settings with one instantiable block. Latency, data width, flag width and tag width are all set per instance.
- Adds valid/ready backpressure, bubble collapsing, flush and occupancy reporting.
- Sits between an operation unit's result and the APU result interface.

Parameters:
- WIDTH, 32, result width (C_FLEN).
- NUM_FLAGS, 5, exception-flag width (C_FFLAG).
- TAG_W, 5, operation tag width (destination register / APU id).
- NUM_STAGES, 1, pipeline register stages, legal 0..8. 0 = combinational passthrough.
- OCC_W, $clog2(NUM_STAGES+1) with minimum 1, occupancy counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all in-flight entries
- in_valid_i  in  1  upstream result valid
- in_ready_o  out  1  pipe can accept this cycle
- in_result_i  in  WIDTH  result
- in_flags_i  in  NUM_FLAGS  NV/DZ/OF/UF/NX flags
- in_tag_i  in  TAG_W  operation tag
- out_valid_o  out  1  result valid at output
- out_ready_i  in  1  downstream accepts
- out_result_o  out  WIDTH  result
- out_flags_o  out  NUM_FLAGS  flags
- out_tag_o  out  TAG_W  tag
- busy_o  out  1  any stage valid, or in_valid_i high
- occupancy_o  out  OCC_W  number of valid stages

Behaviour:
- Stages are numbered 0 (input side) to NUM_STAGES-1 (output side).
- Each stage holds valid_q[k] plus result, flags and tag.
- Stage ready: ready[k] = !valid_q[k] | ready[k+1]. ready[NUM_STAGES] = out_ready_i. Ready is combinational back to front.
- in_ready_o = ready[0].
- out_valid_o and out_* are driven from the last stage.
- Stage k loads from stage k-1 (or from the input, for k=0) when ready[k]=1. Its valid bit takes the upstream valid.
- Payload registers load only on a valid transfer. The payload is otherwise held.
- Bubble collapse: an empty stage always accepts, even when downstream is stalled.
- Throughput: 1 item per cycle. A stall holds data stable. No item is lost or duplicated.
- Latency: an item accepted at edge t shows out_valid_o=1 after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles from in_valid_i, given no stall.
- NUM_STAGES=0: out_* = in_*, in_ready_o = out_ready_i, occupancy_o = 0. flush_i has no effect.
- Flush: at the next edge all valid_q are cleared. An input presented in the flush cycle is dropped, even if in_ready_o=1. Flush takes priority over every transfer in that cycle. Payload values are don't-care afterwards.
- Simultaneous push/pop when full: allowed. ready propagates from out_ready_i, so a full pipe accepts when the output is consumed.
- occupancy_o is the popcount of valid_q. It is registered and updated every edge, never exceeds NUM_STAGES, and is 0 after flush.
- busy_o = |valid_q | in_valid_i (combinational).
- Reset (asynchronous, active-low): all valid_q = 0, all payload registers = 0, out_valid_o = 0, out_* = 0, occupancy_o = 0.
- Reset mid-operation discards all entries immediately, with no output pulse.
- in_ready_o during reset = 1 when NUM_STAGES>0; the pipe is empty.
- Input stability: the upstream must hold in_* stable while in_valid_i=1 and in_ready_o=0. The block does not check this.

Test Plan:
- NUM_STAGES=3, out_ready_i=1; push result 0x3F800000 tag 5 flags 0x01 at cycle 0 -> out_valid_o=1 at cycle 3 with identical payload. occupancy_o goes 1,2,3 during back-to-back pushes of 3 items.
- NUM_STAGES=2; push 4 items back-to-back with out_ready_i=0 -> in_ready_o drops after 2 accepted, occupancy_o=2. Raise out_ready_i -> items exit in order 0,1, then 2,3. No loss.
- NUM_STAGES=4; push one item, stall output until it reaches stage 3, then push a second item -> second item collapses into stage 2 within 2 cycles. occupancy_o=2.
- NUM_STAGES=3 with 3 items in flight; assert flush_i together with in_valid_i -> next cycle out_valid_o=0, occupancy_o=0, flushed-cycle input never emerges.
- Drop rst_ni asynchronously mid-cycle with 2 items in flight -> out_valid_o=0 and occupancy_o=0 immediately. After release, the first new push emerges after NUM_STAGES cycles.
- NUM_STAGES=0 -> out_* equals in_* in the same cycle, in_ready_o follows out_ready_i, occupancy_o=0.
